// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
//   Bit-serial ADD / SUB / NEG / INC controller built around a single
//   full-adder cell that is stepped LSB-first over WIDTH clock cycles.
//   SUB, NEG and INC all reuse the adder as A + B' + 1 with a suitably
//   prepared B' (and A' for NEG), so no extra arithmetic is needed.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      operation request, sampled only while idle
//   op         00 ADD a+b, 01 SUB a-b, 10 NEG -a, 11 INC a+1
//   a, b       operands, latched when start is accepted
//   busy       high for the WIDTH cycles in which bits are computed
//   done       one-cycle pulse; result/carry_out/overflow valid
//   result     result, held until the next operation completes
//   carry_out  carry out of the MSB
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
module serial_addsub_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_NEG = 2'b10,
        OP_INC = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             c_q, c_d;
    // Holds the WIDTH-1 sum bits produced so far; the final bit is merged
    // straight into the result so the port never shows partial values.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             sum;
    logic             c_next;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            c_q      <= 1'b0;
            shreg_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            c_q      <= c_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        c_d      = c_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;

        sum     = opa_q[0] ^ opb_q[0] ^ c_q;
        c_next  = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
        shifted = {sum, shreg_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = S_RUN;
                    unique case (op_t'(op))
                        OP_ADD: begin
                            opa_d = a;
                            opb_d = b;
                            c_d   = 1'b0;
                        end
                        OP_SUB: begin
                            opa_d = a;
                            opb_d = ~b;
                            c_d   = 1'b1;
                        end
                        OP_NEG: begin
                            opa_d = ~a;
                            opb_d = '0;
                            c_d   = 1'b1;
                        end
                        OP_INC: begin
                            opa_d = a;
                            opb_d = '0;
                            c_d   = 1'b1;
                        end
                        default: begin
                            opa_d = a;
                            opb_d = b;
                            c_d   = 1'b0;
                        end
                    endcase
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                c_d     = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                shreg_d = shifted[WIDTH-1:1];
                if (cnt_q == LAST_BIT) begin
                    result_d = shifted;
                    carry_d  = c_next;
                    // c_q is the carry into the MSB cell at this point.
                    ovf_d    = c_q ^ c_next;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;

    localparam int W    = 6;
    localparam int MAXS = 2 ** (W - 1) - 1;
    localparam int MINS = -(2 ** (W - 1));

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int     n_assert = 0;
    int     n_fail = 0;
    int     done_cnt = 0;
    logic [W-1:0] last_r = '0;
    exp_t   sb[$];

    serial_addsub_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry_out(carry_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int ua, ub, sa, sbv, full, tru;
        ua  = int'(av);
        ub  = int'(bv);
        sa  = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
        sbv = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
        case (o)
            2'b00: begin full = ua + ub; e.c = (full >= 2 ** W); tru = sa + sbv; end
            2'b01: begin full = ua - ub; e.c = (ua >= ub);       tru = sa - sbv; end
            2'b10: begin full = -ua;     e.c = (ua == 0);        tru = -sa;      end
            default: begin full = ua + 1; e.c = (ua == 2 ** W - 1); tru = sa + 1; end
        endcase
        e.r = W'(full);
        e.v = (tru > MAXS) || (tru < MINS);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        exp_t e;
        int   d0;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        sb.push_back(model(o, av, bv));
        d0 = done_cnt;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("result_hold", result, last_r);
            if (hold && i == 0) begin
                a  = ~av;
                b  = av ^ bv;
                op = ~o;
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("carry_out", carry_out, e.c);
            chk("overflow", overflow, e.v);
            last_r = e.r;
        end
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_hold", busy, 0);
            chk("done_after_hold", done, 0);
        end
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("one_done", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Leave a non-zero result behind so the reset clear is visible.
        do_op(2'b00, 6'b011111, 6'b000001, 1'b0);

        // Reset in the third RUN cycle.
        @(negedge clk);
        op = 2'b01; a = 6'b010101; b = 6'b000111; start = 1'b1;
        sb.push_back(model(2'b01, 6'b010101, 6'b000111));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_pre_reset", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_carry", carry_out, 0);
        chk("arst_ovf", overflow, 0);
        sb.delete();
        last_r = '0;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", done_cnt - d0, 0);
        chk("idle_after_reset", busy, 0);

        // Directed cases and boundaries.
        do_op(2'b10, 6'b000001, 6'b110011, 1'b0);
        do_op(2'b10, 6'b100000, 6'b000000, 1'b0);
        do_op(2'b10, 6'b000000, 6'b111111, 1'b0);
        do_op(2'b10, 6'b101010, 6'b000000, 1'b0);
        do_op(2'b01, 6'b000011, 6'b000001, 1'b0);
        do_op(2'b00, 6'b011111, 6'b000001, 1'b0);
        do_op(2'b11, 6'b111111, 6'b000000, 1'b0);
        do_op(2'b11, 6'b011111, 6'b000000, 1'b0);
        do_op(2'b01, 6'b000000, 6'b000001, 1'b0);

        // start held through RUN and DONE with operands changed after acceptance.
        do_op(2'b01, 6'b100101, 6'b001110, 1'b1);
        do_op(2'b00, 6'b111000, 6'b010111, 1'b1);

        for (int i = 0; i < 20; i++) begin
            do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
